// File: rtl/prog_loader.sv
// prog_loader: boot/reload sequencer for the one-cycle core.
//
// The loader holds the core in reset through cpu_rst while it streams {instr, arg}
// byte pairs from the host byte port into program memory. It releases the core after
// a fixed hold time. A start pulse in RUN begins a load of len words. Each word takes
// at least three cycles: RX_I, RX_A and WR.
//
// Optional feature macro: CHECKSUM_EN
//   When defined, a running XOR of every accepted byte is kept. One checksum byte is
//   accepted after the last word. A mismatch parks the loader in FAIL, with cpu_rst,
//   busy and err held high, until the next start.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, len         load request (sampled in RUN, and in FAIL with CHECKSUM_EN)
//   s_data/valid/ready host byte stream; a transfer is s_valid & s_ready
//   pm_addr/instr/arg  program-memory write word
//   pm_we              one-cycle write strobe per word
//   cpu_rst            core hold, ORed externally into pc_rst
//   busy               high outside RUN
//   done               one-cycle pulse when a completed load releases the core
//   err                len==0 start pulse, or a held checksum failure
//
// All outputs are registered.
module prog_loader #(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic [WIDTH-1:0]      pm_instr,
    output logic [WIDTH-1:0]      pm_arg,
    output logic                  pm_we,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_RX_I,
        S_RX_A,
`ifdef CHECKSUM_EN
        S_WR,
        S_RX_CK,
        S_FAIL
`else
        S_WR
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [HCW-1:0]        hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    // Set when HOLD was entered from a finished load, so done only follows real loads.
    logic                  loaded_q, loaded_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WIDTH-1:0]      instr_d, arg_d;
    logic                  we_d, rdy_d, rst_d, busy_d, done_d, err_d;
    logic                  xfer;
`ifdef CHECKSUM_EN
    logic [WIDTH-1:0]      csum_q, csum_d;
`endif

    // s_ready is the registered output, so the transfer is fully known at the edge.
    assign xfer = s_valid & s_ready;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        wcnt_d   = wcnt_q;
        len_d    = len_q;
        loaded_d = loaded_q;
        addr_d   = pm_addr;
        instr_d  = pm_instr;
        arg_d    = pm_arg;
        we_d     = 1'b0;
        rdy_d    = s_ready;
        rst_d    = cpu_rst;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = err;
`ifdef CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d  = S_RUN;
                    hold_d   = '0;
                    rst_d    = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = loaded_q;
                    loaded_d = 1'b0;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            S_RUN: begin
                err_d = 1'b0;
                if (start) begin
                    if (len != '0) begin
                        state_d = S_RX_I;
                        len_d   = len;
                        wcnt_d  = '0;
                        rst_d   = 1'b1;
                        busy_d  = 1'b1;
                        rdy_d   = 1'b1;
`ifdef CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RX_I: begin
                if (xfer) begin
                    instr_d = s_data;
                    state_d = S_RX_A;
`ifdef CHECKSUM_EN
                    csum_d  = csum_q ^ s_data;
`endif
                end
            end
            S_RX_A: begin
                if (xfer) begin
                    arg_d   = s_data;
                    addr_d  = wcnt_q;
                    we_d    = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = S_WR;
`ifdef CHECKSUM_EN
                    csum_d  = csum_q ^ s_data;
`endif
                end
            end
            S_WR: begin
                wcnt_d = wcnt_q + ADDR_WIDTH'(1);
                if (wcnt_q == len_q - ADDR_WIDTH'(1)) begin
`ifdef CHECKSUM_EN
                    state_d = S_RX_CK;
                    rdy_d   = 1'b1;
`else
                    state_d  = S_HOLD;
                    hold_d   = '0;
                    loaded_d = 1'b1;
`endif
                end else begin
                    state_d = S_RX_I;
                    rdy_d   = 1'b1;
                end
            end
`ifdef CHECKSUM_EN
            S_RX_CK: begin
                if (xfer) begin
                    rdy_d = 1'b0;
                    if (s_data == csum_q) begin
                        state_d  = S_HOLD;
                        hold_d   = '0;
                        loaded_d = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            S_FAIL: begin
                // A restart from FAIL behaves like a restart from RUN. A len==0
                // start leaves the failure in place.
                if (start && (len != '0)) begin
                    state_d = S_RX_I;
                    len_d   = len;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                    rdy_d   = 1'b1;
                    csum_d  = '0;
                end
            end
`endif
            default: begin
                state_d = S_HOLD;
                hold_d  = '0;
                rdy_d   = 1'b0;
                rst_d   = 1'b1;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HOLD;
            hold_q   <= '0;
            wcnt_q   <= '0;
            len_q    <= '0;
            loaded_q <= 1'b0;
            pm_addr  <= '0;
            pm_instr <= '0;
            pm_arg   <= '0;
            pm_we    <= 1'b0;
            s_ready  <= 1'b0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wcnt_q   <= wcnt_d;
            len_q    <= len_d;
            loaded_q <= loaded_d;
            pm_addr  <= addr_d;
            pm_instr <= instr_d;
            pm_arg   <= arg_d;
            pm_we    <= we_d;
            s_ready  <= rdy_d;
            cpu_rst  <= rst_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
`ifdef CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (default parameters: 8-bit bytes and addresses, 4-cycle hold).
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] pm_addr, pm_instr, pm_arg;
    logic       pm_we, cpu_rst, busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;

    // Write log and event counters, sampled on the falling edge.
    logic [7:0] w_addr[$];
    logic [7:0] w_instr[$];
    logic [7:0] w_arg[$];
    int         done_cnt = 0;
    int         rdy_viol = 0;

    prog_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .pm_addr  (pm_addr),
        .pm_instr (pm_instr),
        .pm_arg   (pm_arg),
        .pm_we    (pm_we),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_we) begin
            w_addr.push_back(pm_addr);
            w_instr.push_back(pm_instr);
            w_arg.push_back(pm_arg);
            if (s_ready) rdy_viol++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic clr_log();
        w_addr.delete();
        w_instr.delete();
        w_arg.delete();
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [7:0] a,
                          input logic [7:0] i, input logic [7:0] g);
        if (idx < w_addr.size()) begin
            chk({tag, "_addr"}, w_addr[idx], a);
            chk({tag, "_instr"}, w_instr[idx], i);
            chk({tag, "_arg"}, w_arg[idx], g);
        end else begin
            chk({tag, "_missing"}, 0, 1);
        end
    endtask

    task automatic pulse_start(input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits gap idle cycles (optionally pulsing start during them). It then offers b
    // until it is taken. s_valid stays high afterwards, so consecutive calls give
    // back-to-back traffic.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic mid_start);
        logic r;
        bit   ok;
        ok = 0;
        for (int k = 0; k < gap; k++) begin
            s_valid = 1'b0;
            start   = mid_start;
            len     = 8'd5;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk); #1;
            if (r) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    // Counts the cycles cpu_rst stays high. It then checks the release cycle and the
    // cycle after it.
    task automatic wait_release(input string tag, input int exp_hold, input logic exp_done);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cpu_rst) n++;
            else break;
        end
        chk({tag, "_hold"}, n, exp_hold);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_end"}, done, 0);
    endtask

    initial begin
        int d0;
        rst_n   = 1'b0;
        start   = 1'b0;
        len     = 8'd0;
        s_data  = 8'd0;
        s_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_pm_we", pm_we, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pm", {pm_addr, pm_instr, pm_arg}, 0);

        // 1: boot hold of exactly 4 cycles, no done
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_release("boot", 4, 0);
        chk("boot_done_cnt", done_cnt, 0);

        // 2: len=2 with back-to-back bytes
        clr_log();
        pulse_start(8'd2);
        chk("t2_busy", busy, 1);
        chk("t2_cpu_rst", cpu_rst, 1);
        send_byte(8'h0A, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h0B, 0, 0);
        send_byte(8'h22, 0, 0);
        s_valid = 1'b0;
        wait_release("t2", 5, 1);
        chk("t2_nwr", w_addr.size(), 2);
        chk_wr("t2_w0", 0, 8'h00, 8'h0A, 8'h11);
        chk_wr("t2_w1", 1, 8'h01, 8'h0B, 8'h22);
        chk("t2_done_cnt", done_cnt, 1);

        // 3: len=0 produces a one-cycle err pulse and stays in RUN
        clr_log();
        pulse_start(8'd0);
        @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cpu_rst", cpu_rst, 0);
        chk("t3_s_ready", s_ready, 0);
        @(negedge clk);
        chk("t3_err_end", err, 0);
        chk("t3_busy2", busy, 0);
        chk("t3_nwr", w_addr.size(), 0);

        // 4: len=3 with gaps and ignored mid-load starts
        clr_log();
        pulse_start(8'd3);
        send_byte(8'h31, 0, 0);
        send_byte(8'h41, 2, 1);
        send_byte(8'h32, 1, 0);
        send_byte(8'h42, 3, 1);
        send_byte(8'h33, 0, 0);
        send_byte(8'h43, 2, 1);
        s_valid = 1'b0;
        wait_release("t4", 5, 1);
        chk("t4_nwr", w_addr.size(), 3);
        chk_wr("t4_w0", 0, 8'h00, 8'h31, 8'h41);
        chk_wr("t4_w1", 1, 8'h01, 8'h32, 8'h42);
        chk_wr("t4_w2", 2, 8'h02, 8'h33, 8'h43);

        // 5: reset in RX_A, then reset while pm_we is high
        d0 = done_cnt;
        clr_log();
        pulse_start(8'd2);
        send_byte(8'h55, 0, 0);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_pm_we", pm_we, 0);
        chk("t5_cpu_rst", cpu_rst, 1);
        chk("t5_s_ready", s_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_release("t5", 4, 0);
        pulse_start(8'd1);
        send_byte(8'h66, 0, 0);
        send_byte(8'h77, 0, 0);
        s_valid = 1'b0;
        chk("t5b_we_pre", pm_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5b_we_async", pm_we, 0);
        chk("t5b_cpu_rst", cpu_rst, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_release("t5b", 4, 0);
        chk("t5_done_cnt", done_cnt, d0);
        chk("t5_nwr", w_addr.size(), 0);
        pulse_start(8'd1);
        send_byte(8'h12, 0, 0);
        send_byte(8'h34, 0, 0);
        s_valid = 1'b0;
        wait_release("t5c", 5, 1);
        chk("t5c_nwr", w_addr.size(), 1);
        chk_wr("t5c_w0", 0, 8'h00, 8'h12, 8'h34);

        // Largest load: len=255, addresses 0..254
        clr_log();
        pulse_start(8'd255);
        for (int k = 0; k < 255; k++) begin
            logic [7:0] b;
            b = k[7:0];
            send_byte(b, 0, 0);
            send_byte(~b, 0, 0);
        end
        s_valid = 1'b0;
        wait_release("big", 5, 1);
        chk("big_nwr", w_addr.size(), 255);
        chk_wr("big_first", 0, 8'h00, 8'h00, 8'hFF);
        chk_wr("big_last", 254, 8'hFE, 8'hFE, 8'h01);

`ifdef CHECKSUM_EN
        // 6: checksum match, then mismatch and FAIL, then a reload from FAIL
        clr_log();
        pulse_start(8'd1);
        send_byte(8'h0A, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h1B, 0, 0);
        s_valid = 1'b0;
        wait_release("ck_ok", 4, 1);
        chk_wr("ck_w0", 0, 8'h00, 8'h0A, 8'h11);
        d0 = done_cnt;
        pulse_start(8'd1);
        send_byte(8'h0A, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h00, 0, 0);
        s_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("ck_fail_err", err, 1);
        chk("ck_fail_rst", cpu_rst, 1);
        chk("ck_fail_busy", busy, 1);
        chk("ck_fail_done", done_cnt, d0);
        clr_log();
        pulse_start(8'd1);
        send_byte(8'h0C, 0, 0);
        send_byte(8'h0D, 0, 0);
        send_byte(8'h01, 0, 0);
        s_valid = 1'b0;
        wait_release("ck_re", 4, 1);
        chk("ck_re_err", err, 0);
        chk_wr("ck_re_w0", 0, 8'h00, 8'h0C, 8'h0D);
`endif

        chk("rdy_in_wr", rdy_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
